usb_pkt_rx: RTL and testbench

USB_PKT_RX -- requirements
Module: usb_pkt_rx

---
 rtl/usb_pkt_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_usb_pkt_rx.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_pkt_rx.sv
// usb_pkt_rx: UTMI-style USB packet receiver. It decodes the PID, checks token CRC5 and
// data CRC16, and streams the data payload through a 2-byte delay so CRC bytes never appear.
module usb_pkt_rx #(
  parameter int MAX_BYTES = 1026
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_active,
  input  logic        rx_error,
  output logic [7:0]  pid,
  output logic [23:0] token_in,
  output logic        token_in_strb,
  output logic [7:0]  data_in,
  output logic        data_in_strb,
  output logic        data_in_end,
  output logic        data_in_fail
);

  typedef enum logic [2:0] {IDLE, GET_PID, TOKEN, DATA, HSHK, DRAIN} state_t;

  localparam logic [4:0]  CRC5_RES  = 5'b01100;
  localparam logic [15:0] CRC16_RES = 16'h800D;
  localparam logic [10:0] CNT_SAT   = 11'h7FF;
  localparam logic [10:0] MAX_CNT   = 11'(MAX_BYTES);

  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[3:0], 1'b0} ^ ((d[i] ^ r[4]) ? 5'h05 : 5'h00);
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[14:0], 1'b0} ^ ((d[i] ^ r[15]) ? 16'h8005 : 16'h0000);
    return r;
  endfunction

  state_t      state, state_n;
  logic        active_q;
  logic [7:0]  pid_n, data_n, b1, b1_n, b2, b2_n, buf0, buf0_n, buf1, buf1_n;
  logic [23:0] token_n;
  logic        tok_strb_n, dat_strb_n, end_n, fail_n;
  logic [4:0]  crc5, crc5_n, crc5_upd;
  logic [15:0] crc16, crc16_n, crc16_upd;
  logic [10:0] cnt, cnt_n, cnt_inc;
  logic        err_seen, err_n;
  logic [1:0]  bcnt, bcnt_n;
  logic        pend_end, pend_fail, pend_end_n, pend_fail_n;
  logic        pid_ok, ovf, pkt_ok;

  assign pid_ok    = (rx_data[7:4] == ~rx_data[3:0]);
  assign crc5_upd  = crc5_byte(crc5, rx_data);
  assign crc16_upd = crc16_byte(crc16, rx_data);
  assign cnt_inc   = (cnt == CNT_SAT) ? cnt : cnt + 11'd1;

  // In every non-IDLE state, rx_active=0 is the end-of-packet cycle; a byte arriving
  // in that same cycle is folded in before the end decision.
  always_comb begin
    state_n     = state;
    pid_n       = pid;
    token_n     = token_in;
    data_n      = data_in;
    tok_strb_n  = 1'b0;
    dat_strb_n  = 1'b0;
    end_n       = 1'b0;
    fail_n      = 1'b0;
    b1_n        = b1;
    b2_n        = b2;
    crc5_n      = crc5;
    crc16_n     = crc16;
    cnt_n       = cnt;
    err_n       = err_seen;
    buf0_n      = buf0;
    buf1_n      = buf1;
    bcnt_n      = bcnt;
    pend_end_n  = 1'b0;
    pend_fail_n = 1'b0;
    ovf         = 1'b0;
    pkt_ok      = 1'b0;
    case (state)
      IDLE: begin
        crc5_n  = 5'h1F;
        crc16_n = 16'hFFFF;
        cnt_n   = '0;
        err_n   = 1'b0;
        bcnt_n  = '0;
        end_n   = pend_end;
        fail_n  = pend_fail;
        if (rx_active && !active_q) state_n = GET_PID;
      end
      GET_PID: begin
        if (!rx_active) begin
          state_n = IDLE;
          if (rx_valid && pid_ok) begin
            pid_n  = rx_data;
            fail_n = (rx_data[1:0] == 2'b11);
          end
        end else if (rx_error) begin
          state_n = DRAIN;
        end else if (rx_valid) begin
          if (!pid_ok) begin
            state_n = DRAIN;
          end else begin
            pid_n = rx_data;
            case (rx_data[1:0])
              2'b01:   state_n = TOKEN;
              2'b11:   state_n = DATA;
              2'b10:   state_n = HSHK;
              default: state_n = DRAIN;
            endcase
          end
        end
      end
      TOKEN: begin
        if (rx_valid) begin
          cnt_n  = cnt_inc;
          crc5_n = crc5_upd;
          if (cnt == 11'd0) b1_n = rx_data;
          if (cnt == 11'd1) b2_n = rx_data;
        end
        if (rx_error) err_n = 1'b1;
        if (!rx_active) begin
          state_n = IDLE;
          if (cnt_n == 11'd2 && crc5_n == CRC5_RES && !err_n) begin
            token_n    = {pid, b1_n, b2_n};
            tok_strb_n = 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_error) begin
          fail_n  = 1'b1;
          state_n = rx_active ? DRAIN : IDLE;
        end else begin
          if (rx_valid) begin
            crc16_n = crc16_upd;
            cnt_n   = cnt_inc;
            if (cnt_inc > MAX_CNT) begin
              ovf     = 1'b1;
              fail_n  = 1'b1;
              state_n = rx_active ? DRAIN : IDLE;
            end else if (bcnt == 2'd2) begin
              data_n     = buf0;
              dat_strb_n = 1'b1;
              buf0_n     = buf1;
              buf1_n     = rx_data;
            end else if (bcnt == 2'd1) begin
              buf1_n = rx_data;
              bcnt_n = 2'd2;
            end else begin
              buf0_n = rx_data;
              bcnt_n = 2'd1;
            end
          end
          if (!rx_active && !ovf) begin
            state_n = IDLE;
            pkt_ok  = (cnt_n >= 11'd2) && (crc16_n == CRC16_RES);
            // A payload strobe already owns this cycle, so the verdict goes out one cycle later.
            if (dat_strb_n) begin
              pend_end_n  = pkt_ok;
              pend_fail_n = !pkt_ok;
            end else begin
              end_n  = pkt_ok;
              fail_n = !pkt_ok;
            end
          end
        end
      end
      HSHK: begin
        if (!rx_active)    state_n = IDLE;
        else if (rx_valid) state_n = DRAIN;
      end
      DRAIN: begin
        if (!rx_active) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // Sampled even in reset so a packet still in flight at release is not mistaken for a new one.
    active_q <= rx_active;
    if (!nrst) begin
      state         <= IDLE;
      pid           <= '0;
      token_in      <= '0;
      data_in       <= '0;
      token_in_strb <= 1'b0;
      data_in_strb  <= 1'b0;
      data_in_end   <= 1'b0;
      data_in_fail  <= 1'b0;
      b1            <= '0;
      b2            <= '0;
      crc5          <= 5'h1F;
      crc16         <= 16'hFFFF;
      cnt           <= '0;
      err_seen      <= 1'b0;
      buf0          <= '0;
      buf1          <= '0;
      bcnt          <= '0;
      pend_end      <= 1'b0;
      pend_fail     <= 1'b0;
    end else begin
      state         <= state_n;
      pid           <= pid_n;
      token_in      <= token_n;
      data_in       <= data_n;
      token_in_strb <= tok_strb_n;
      data_in_strb  <= dat_strb_n;
      data_in_end   <= end_n;
      data_in_fail  <= fail_n;
      b1            <= b1_n;
      b2            <= b2_n;
      crc5          <= crc5_n;
      crc16         <= crc16_n;
      cnt           <= cnt_n;
      err_seen      <= err_n;
      buf0          <= buf0_n;
      buf1          <= buf1_n;
      bcnt          <= bcnt_n;
      pend_end      <= pend_end_n;
      pend_fail     <= pend_fail_n;
    end
  end

endmodule

// File: tb/tb_usb_pkt_rx.sv
// Bench for usb_pkt_rx: table of packet vectors plus hand sequences for the corner cases,
// with every strobe checked against an expected-event queue.
module tb_usb_pkt_rx;

  localparam int W = 26;
  localparam int MAXB = 1026;
  localparam int EV_DATA = 0, EV_END = 1, EV_FAIL = 2, EV_TOK = 3, EV_NONE = 4;
  localparam int K_DATA = 0, K_TOKEN = 1, K_HSHK = 2, K_BADPID = 3;
  localparam int NVEC = 17;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_active = 1'b0;
  logic        rx_error = 1'b0;
  logic [7:0]  pid;
  logic [23:0] token_in;
  logic        token_in_strb;
  logic [7:0]  data_in;
  logic        data_in_strb;
  logic        data_in_end;
  logic        data_in_fail;

  usb_pkt_rx #(.MAX_BYTES(MAXB)) dut (
    .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_active(rx_active), .rx_error(rx_error), .pid(pid), .token_in(token_in),
    .token_in_strb(token_in_strb), .data_in(data_in), .data_in_strb(data_in_strb),
    .data_in_end(data_in_end), .data_in_fail(data_in_fail)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   tx_q[$];
  logic [7:0]   pay_q[$];
  logic [23:0]  last_tok;

  typedef struct {
    int         kind;
    logic [7:0] pid_b;
    int         len;
    bit         bad;
    int         err_at;
    int         nstrb;
    int         last;
    logic [7:0] exp_pid;
  } vec_t;

  vec_t vec[NVEC];

  function automatic logic [W-1:0] ev(input int k, input logic [23:0] val);
    return {2'(k), val};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  // Packet builders: CRC is generated here so the DUT must see a well-formed packet.
  task automatic build_token(input logic [7:0] p, input bit bad);
    logic [10:0] v;
    logic [4:0]  c, t;
    logic [7:0]  b1, b2;
    logic        fb;
    v = 11'($urandom_range(0, 2047));
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = v[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    t  = ~c;
    b1 = v[7:0];
    b2 = {t[0], t[1], t[2], t[3], t[4], v[10:8]};
    if (bad) b2 = b2 ^ 8'h80;
    tx_q.push_back(p);
    tx_q.push_back(b1);
    tx_q.push_back(b2);
    last_tok = {p, b1, b2};
  endtask

  task automatic build_data(input logic [7:0] p, input int len, input bit bad);
    logic [15:0] c, t;
    logic [7:0]  b, c0, c1;
    logic        fb;
    c = 16'hFFFF;
    tx_q.push_back(p);
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      pay_q.push_back(b);
      tx_q.push_back(b);
      for (int i = 0; i < 8; i++) begin
        fb = b[i] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    t = ~c;
    for (int j = 0; j < 8; j++) begin
      c0[j] = t[15-j];
      c1[j] = t[7-j];
    end
    if (bad) c1 = c1 ^ 8'h01;
    tx_q.push_back(c0);
    tx_q.push_back(c1);
  endtask

  // driver: err_at is the tx_q index after which rx_error pulses (-1 = none)
  task automatic send_pkt(input int gap_max, input int err_at, input bit last_on_fall);
    rx_active = 1'b1;
    tick();
    for (int i = 0; i < tx_q.size(); i++) begin
      rx_data  = tx_q[i];
      rx_valid = 1'b1;
      if (last_on_fall && i == tx_q.size() - 1) rx_active = 1'b0;
      tick();
      rx_valid = 1'b0;
      if (err_at >= 0 && i == err_at) begin
        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
      end
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    end
    if (!last_on_fall) begin
      rx_active = 1'b0;
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0]   s;
      logic [W-1:0] act, e;
      s = {token_in_strb, data_in_fail, data_in_end, data_in_strb};
      if ($countones(s) > 1) begin
        checks++;
        failures++;
        $display("FAIL exclusive_strobes act=%b exp=one-hot", s);
      end else if (s != 4'b0000) begin
        if (data_in_strb)      act = ev(EV_DATA, {16'h0, data_in});
        else if (data_in_end)  act = ev(EV_END, 24'h0);
        else if (data_in_fail) act = ev(EV_FAIL, 24'h0);
        else                   act = ev(EV_TOK, token_in);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event act=%h exp=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL event act=%h exp=%h", act, e);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] p0, p1;

    vec[0]  = '{K_DATA,   8'hC3, 0,    1'b0, -1, 0,    EV_END,  8'hC3};
    vec[1]  = '{K_DATA,   8'h4B, 1,    1'b0, -1, 1,    EV_END,  8'h4B};
    vec[2]  = '{K_DATA,   8'hC3, 5,    1'b0, -1, 5,    EV_END,  8'hC3};
    vec[3]  = '{K_DATA,   8'h4B, 8,    1'b1, -1, 8,    EV_FAIL, 8'h4B};
    vec[4]  = '{K_DATA,   8'hC3, 6,    1'b0, 4,  2,    EV_FAIL, 8'hC3};
    vec[5]  = '{K_TOKEN,  8'h2D, 0,    1'b0, -1, 0,    EV_TOK,  8'h2D};
    vec[6]  = '{K_TOKEN,  8'h69, 0,    1'b0, -1, 0,    EV_TOK,  8'h69};
    vec[7]  = '{K_TOKEN,  8'hE1, 0,    1'b1, -1, 0,    EV_NONE, 8'hE1};
    vec[8]  = '{K_HSHK,   8'hD2, 0,    1'b0, -1, 0,    EV_NONE, 8'hD2};
    vec[9]  = '{K_BADPID, 8'h5B, 0,    1'b0, -1, 0,    EV_NONE, 8'hD2};
    vec[10] = '{K_TOKEN,  8'h69, 0,    1'b0, 1,  0,    EV_NONE, 8'h69};
    vec[11] = '{K_DATA,   8'hC3, 64,   1'b0, -1, 64,   EV_END,  8'hC3};
    vec[12] = '{K_HSHK,   8'h5A, 0,    1'b0, -1, 0,    EV_NONE, 8'h5A};
    vec[13] = '{K_HSHK,   8'h3C, 0,    1'b0, -1, 0,    EV_NONE, 8'h3C};
    vec[14] = '{K_DATA,   8'h4B, 1024, 1'b0, -1, 1024, EV_END,  8'h4B};
    vec[15] = '{K_DATA,   8'hC3, 1025, 1'b0, -1, 1024, EV_FAIL, 8'hC3};
    vec[16] = '{K_DATA,   8'h4B, 2,    1'b0, 1,  0,    EV_FAIL, 8'h4B};

    // reset state
    repeat (3) tick();
    check("rst_pid", pid, 8'h00);
    check("rst_token", token_in, 24'h0);
    check("rst_data", data_in, 8'h00);
    check("rst_strobes", {token_in_strb, data_in_strb, data_in_end, data_in_fail}, 4'b0000);
    nrst = 1'b1;
    tick();
    mon_en = 1'b1;

    // good SETUP token, strobe exactly one cycle after the fall
    tx_q = '{8'h2D, 8'h00, 8'h10};
    exp_q.push_back(ev(EV_TOK, 24'h2D0010));
    send_pkt(0, -1, 1'b0);
    check("setup_strb", token_in_strb, 1);
    check("setup_token", token_in, 24'h2D0010);
    tick();
    check("setup_strb_width", token_in_strb, 0);
    check("setup_pid", pid, 8'h2D);

    // good DATA0 then the same with a corrupted CRC
    for (int pass = 0; pass < 2; pass++) begin
      tx_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
      if (pass == 1) tx_q[10] = 8'h95;
      pay_q = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
      foreach (pay_q[k]) exp_q.push_back(ev(EV_DATA, {16'h0, pay_q[k]}));
      exp_q.push_back(ev(pass == 0 ? EV_END : EV_FAIL, 24'h0));
      send_pkt(1, -1, 1'b0);
      settle();
      check($sformatf("data0_drain_%0d", pass), exp_q.size(), 0);
    end

    // bad PID: no pulse, pid unchanged, next token fine
    tx_q = '{8'h2C, 8'h00, 8'h10};
    send_pkt(0, -1, 1'b0);
    settle();
    check("badpid_pid", pid, 8'hC3);
    check("badpid_drain", exp_q.size(), 0);
    tx_q.delete();
    build_token(8'hE1, 1'b0);
    exp_q.push_back(ev(EV_TOK, last_tok));
    send_pkt(0, -1, 1'b0);
    settle();
    check("after_badpid_token", token_in, last_tok);

    // rx_error after the 4th byte of DATA1
    tx_q.delete();
    pay_q.delete();
    build_data(8'h4B, 6, 1'b0);
    exp_q.push_back(ev(EV_DATA, {16'h0, pay_q[0]}));
    exp_q.push_back(ev(EV_FAIL, 24'h0));
    send_pkt(1, 3, 1'b0);
    settle();
    check("rxerr_drain", exp_q.size(), 0);

    // payload latency and end-pulse timing
    tx_q.delete();
    pay_q.delete();
    build_data(8'hC3, 2, 1'b0);
    p0 = pay_q[0];
    p1 = pay_q[1];
    exp_q.push_back(ev(EV_DATA, {16'h0, p0}));
    exp_q.push_back(ev(EV_DATA, {16'h0, p1}));
    exp_q.push_back(ev(EV_END, 24'h0));
    rx_active = 1'b1;
    tick();
    send_byte(tx_q[0]);
    send_byte(tx_q[1]);
    send_byte(tx_q[2]);
    check("lat_no_strb_yet", data_in_strb, 0);
    send_byte(tx_q[3]);
    check("lat_strb0", data_in_strb, 1);
    check("lat_data0", data_in, p0);
    send_byte(tx_q[4]);
    check("lat_data1", data_in, p1);
    rx_active = 1'b0;
    check("end_not_early", data_in_end, 0);
    tick();
    check("end_timing", data_in_end, 1);
    tick();
    check("end_width", data_in_end, 0);
    settle();

    // last token byte in the same cycle rx_active falls
    tx_q.delete();
    build_token(8'h69, 1'b0);
    exp_q.push_back(ev(EV_TOK, last_tok));
    send_pkt(0, -1, 1'b1);
    check("fallvalid_strb", token_in_strb, 1);
    settle();

    // back-to-back tokens separated by a single low cycle
    tx_q.delete();
    build_token(8'h2D, 1'b0);
    exp_q.push_back(ev(EV_TOK, last_tok));
    send_pkt(0, -1, 1'b0);
    tx_q.delete();
    build_token(8'hE1, 1'b0);
    exp_q.push_back(ev(EV_TOK, last_tok));
    send_pkt(0, -1, 1'b0);
    settle();
    check("b2b_drain", exp_q.size(), 0);
    check("b2b_pid", pid, 8'hE1);

    // table-driven vectors
    for (int v = 0; v < NVEC; v++) begin
      tx_q.delete();
      pay_q.delete();
      case (vec[v].kind)
        K_DATA:  build_data(vec[v].pid_b, vec[v].len, vec[v].bad);
        K_TOKEN: build_token(vec[v].pid_b, vec[v].bad);
        K_HSHK:  tx_q.push_back(vec[v].pid_b);
        default: begin
          tx_q.push_back(vec[v].pid_b);
          tx_q.push_back(8'($urandom_range(0, 255)));
          tx_q.push_back(8'($urandom_range(0, 255)));
        end
      endcase
      for (int k = 0; k < vec[v].nstrb; k++) exp_q.push_back(ev(EV_DATA, {16'h0, pay_q[k]}));
      if (vec[v].last != EV_NONE)
        exp_q.push_back(ev(vec[v].last, (vec[v].last == EV_TOK) ? last_tok : 24'h0));
      send_pkt(1, vec[v].err_at, 1'b0);
      settle();
      check($sformatf("vec%0d_drain", v), exp_q.size(), 0);
      check($sformatf("vec%0d_pid", v), pid, vec[v].exp_pid);
      if (vec[v].last == EV_TOK) check($sformatf("vec%0d_token", v), token_in, last_tok);
    end

    // reset for one cycle in the middle of a DATA0 packet
    tx_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    exp_q.push_back(ev(EV_DATA, 24'h000080));
    exp_q.push_back(ev(EV_DATA, 24'h000006));
    rx_active = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) send_byte(tx_q[i]);
    tick();
    nrst = 1'b0;
    tick();
    check("midrst_pid", pid, 8'h00);
    check("midrst_token", token_in, 24'h0);
    check("midrst_data", data_in, 8'h00);
    check("midrst_strobes", {token_in_strb, data_in_strb, data_in_end, data_in_fail}, 4'b0000);
    nrst = 1'b1;
    for (int i = 5; i < 11; i++) send_byte(tx_q[i]);
    rx_active = 1'b0;
    tick();
    settle();
    check("midrst_drain", exp_q.size(), 0);
    check("midrst_pid_after", pid, 8'h00);
    tx_q.delete();
    build_token(8'h2D, 1'b0);
    exp_q.push_back(ev(EV_TOK, last_tok));
    send_pkt(0, -1, 1'b0);
    settle();
    check("midrst_token_after", token_in, last_tok);
    check("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
